// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-precision adder/subtractor: one 8-bit column per cycle, LSB first,
// carry chained through a register, result returned over a valid/ready handshake.
module multibyte_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] y,
  output logic                cout,
  output logic                overflow,
  output logic                zero
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      carry_q, carry_d;
  logic [NBYTES-1:0][7:0]    a_q, a_d;
  logic [NBYTES-1:0][7:0]    b_q, b_d;
  logic [NBYTES-1:0][7:0]    y_q, y_d;
  logic                      cout_q, cout_d;
  logic                      overflow_q, overflow_d;
  logic                      zero_q, zero_d;
  logic                      start_ready_q, start_ready_d;
  logic                      res_valid_q, res_valid_d;

  logic [7:0]                a_byte, b_byte;
  logic [8:0]                sum;
  logic                      carry_msb;

  // Current column through the 8-bit adder slice
  always_comb begin
    a_byte    = a_q[idx_q];
    b_byte    = b_q[idx_q];
    sum       = 9'(a_byte) + 9'(b_byte) + 9'(carry_q);
    carry_msb = a_byte[7] ^ b_byte[7] ^ sum[7];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    y_d         = y_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid && start_ready_q) begin
          // Subtraction runs as a + ~b + ~cin on the same carry chain
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = cin ^ sub;
          y_d        = '0;
          cout_d     = 1'b0;
          overflow_d = 1'b0;
          zero_d     = 1'b0;
          idx_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        y_d[idx_q] = sum[7:0];
        carry_d    = sum[8];
        if (idx_q == LAST_IDX) begin
          cout_d     = sum[8];
          overflow_d = sum[8] ^ carry_msb;
          zero_d     = (y_d == '0);
          state_d    = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    start_ready_d = (state_d == IDLE);
    res_valid_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      y_q           <= '0;
      cout_q        <= 1'b0;
      overflow_q    <= 1'b0;
      zero_q        <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      carry_q       <= carry_d;
      a_q           <= a_d;
      b_q           <= b_d;
      y_q           <= y_d;
      cout_q        <= cout_d;
      overflow_q    <= overflow_d;
      zero_q        <= zero_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign y           = y_q;
  assign cout        = cout_q;
  assign overflow    = overflow_q;
  assign zero        = zero_q;

endmodule

// File: doc/multibyte_add_seq.md
Name: multibyte_add_seq

Overview:
- Byte-serial multi-precision adder/subtractor.
- Accepts two NBYTES-wide operands through a valid/ready handshake and processes them one 8-bit column per cycle, LSB byte first, chaining the carry through a register.
- Reports the sum with carry-out, signed overflow and zero flags through a second valid/ready handshake.
- Sits directly upstream of the datapath's 8-bit adder slice: it sequences operand bytes and carry into that slice and assembles the wide result.

Parameters:
NBYTES, 4, number of 8-bit columns per operand (legal range 1..16)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
start_valid  input  1  request carries valid operands
start_ready  output  1  block can accept a request
sub  input  1  0 = a+b+cin, 1 = a-b-cin
a  input  8*NBYTES  operand A
b  input  8*NBYTES  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
res_valid  output  1  result outputs valid
res_ready  input  1  consumer takes result
y  output  8*NBYTES  sum/difference
cout  output  1  carry out of top column (sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow
zero  output  1  y == 0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset: FSM goes to IDLE. Byte index, carry reg, operand regs, y, cout, overflow, zero, res_valid = 0; start_ready = 1.
- Reset asserted mid-operation aborts the operation. No result is produced and nothing is resumed after reset releases.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1, res_valid = 0.
  - On start_valid & start_ready at a rising edge: latch a; latch b (inverted when sub = 1); carry reg <= cin ^ sub; y <= 0; flags <= 0; idx <= 0; go to RUN.
- RUN:
  - start_ready = 0, res_valid = 0.
  - Each cycle: s = A[idx] + B'[idx] + carry (9-bit).
  - y byte idx <= s[7:0]; carry <= s[8].
  - On idx == NBYTES-1: also capture carry-into-MSB (a7 ^ b'7 ^ s7 of that byte), set cout <= s[8], overflow <= s[8] ^ carry-into-MSB, zero <= (full y with this byte) == 0, go to DONE. Otherwise idx <= idx + 1.
- DONE:
  - res_valid = 1; y and all flags held stable.
  - start_ready = 0; start_valid is ignored.
  - On res_ready: go to IDLE. Outputs keep their values until the next accept clears them.
- Latency: res_valid rises exactly NBYTES rising edges after the accepting edge.
- Throughput: one operation per NBYTES+2 cycles minimum (accept, NBYTES, release).
- Subtraction: a + ~b + ~cin.
  - cout = 1 means no borrow.
  - overflow uses the same carry-in ^ carry-out-of-MSB rule as addition.
- Arithmetic is modulo 2^(8*NBYTES). Wrap-around is reported only via cout and overflow.
- The carry chain is strictly per operation. Carry never leaks between operations.
- Input operands may change freely after the accepting edge.
- NBYTES = 1: RUN lasts one cycle and the final-byte rules apply on idx 0.

Test Plan:
All cases use NBYTES = 4.
1. Add carry ripple: a=0x000000FF, b=0x00000001, cin=0, sub=0 -> after exactly 4 edges res_valid=1, y=0x00000100, cout=0, overflow=0, zero=0; start_ready low from accept until DONE exits.
2. Signed overflow and full wrap:
   - 0x7FFFFFFF + 0x00000001 -> y=0x80000000, overflow=1, cout=0.
   - 0xFFFFFFFF + 0x00000000 with cin=1 -> y=0, cout=1, zero=1, overflow=0.
3. Subtract:
   - sub=1, a=5, b=7, cin=0 -> y=0xFFFFFFFE, cout=0, overflow=0.
   - sub=1, a=0x80000000, b=1 -> y=0x7FFFFFFF, cout=1, overflow=1.
   - sub=1, a=9, b=4, cin=1 -> y=4.
4. Backpressure: hold res_ready=0 for 5 cycles in DONE while pulsing start_valid with new operands -> y and flags unchanged, start_ready=0, no new accept; raise res_ready -> IDLE next edge, then the new request is accepted.
5. Reset mid-operation: assert reset asynchronously (between edges) while idx=2 -> outputs immediately 0, start_ready=1. After release, 0x12345678 + 0x11111111 gives 0x23456789 with all flags 0.
6. Back-to-back stream: 20 random add/sub requests with random start_valid/res_ready gaps -> every result and flag matches the reference model, with no lost or duplicated transaction.
